// File: rtl/fwd_pkg.sv
// Shared select encodings and pipeline-slot record for the forwarding/hazard unit.
package fwd_pkg;

   // Slot rd is stored zero-extended so the record stays fixed-width for any RA_W <= RA_MAX_W.
   localparam int unsigned RA_MAX_W = 8;

   localparam logic [1:0] FWD_SEL_REG = 2'b00;
   localparam logic [1:0] FWD_SEL_WB  = 2'b01;
   localparam logic [1:0] FWD_SEL_MEM = 2'b10;

   typedef struct packed {
      logic                valid;
      logic [RA_MAX_W-1:0] rd;
      logic                rd_we;
      logic                is_load;
   } slot_t;

   // x0 is hard-wired zero, so it never produces a dependency.
   function automatic logic slot_writes(input slot_t s, input logic [RA_MAX_W-1:0] r);
      return s.valid && s.rd_we && (s.rd == r) && (r != '0);
   endfunction

endpackage

// File: rtl/fwd_src_sel.sv
// One EX operand: compares against MEM/WB destinations and picks the operand source.
module fwd_src_sel
   import fwd_pkg::*;
#(
   parameter int XLEN   = 32,
   parameter int RA_W   = 5,
   parameter int FWD_EN = 1
) (
   input  logic [RA_W-1:0] rs_addr,
   input  logic            rs_used,
   input  slot_t           mem_slot,
   input  slot_t           wb_slot,
   input  logic [XLEN-1:0] rs_data,
   input  logic [XLEN-1:0] mem_alu_result,
   input  logic [XLEN-1:0] wb_rd_data,
   output logic [1:0]      fwd_sel,
   output logic [XLEN-1:0] fwd_data
);

   logic [RA_MAX_W-1:0] rs_ext;
   assign rs_ext = RA_MAX_W'(rs_addr);

   always_comb begin
      fwd_sel = FWD_SEL_REG;
      if (FWD_EN != 0 && rs_used) begin
         // A MEM-slot load has no data yet; its consumer was held back one cycle.
         if (slot_writes(mem_slot, rs_ext) && !mem_slot.is_load)
            fwd_sel = FWD_SEL_MEM;
         else if (slot_writes(wb_slot, rs_ext))
            fwd_sel = FWD_SEL_WB;
      end
   end

   always_comb begin
      case (fwd_sel)
         FWD_SEL_MEM: fwd_data = mem_alu_result;
         FWD_SEL_WB:  fwd_data = wb_rd_data;
         default:     fwd_data = rs_data;
      endcase
   end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Forwarding and hazard unit: tracks EX/MEM/WB destinations, selects EX operands,
// raises the ID stall and counts stall cycles.
module fwd_hazard_unit
   import fwd_pkg::*;
#(
   parameter int XLEN    = 32,
   parameter int NUM_SRC = 2,
   parameter int RA_W    = 5,
   parameter int FWD_EN  = 1,
   parameter int CNT_W   = 16
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    id_valid,
   input  logic [NUM_SRC*RA_W-1:0] id_rs_addr,
   input  logic [NUM_SRC-1:0]      id_rs_used,
   input  logic [RA_W-1:0]         id_rd,
   input  logic                    id_rd_we,
   input  logic                    id_is_load,
   input  logic                    flush,
   input  logic [NUM_SRC*XLEN-1:0] ex_rs_data,
   input  logic [XLEN-1:0]         mem_alu_result,
   input  logic [XLEN-1:0]         wb_rd_data,
   output logic                    id_stall,
   output logic [NUM_SRC*2-1:0]    ex_fwd_sel,
   output logic [NUM_SRC*XLEN-1:0] ex_fwd_data,
   output logic [CNT_W-1:0]        stall_cycles
);

   slot_t                   ex_q, mem_q, wb_q;
   logic [NUM_SRC*RA_W-1:0] ex_rs_addr_q;
   logic [NUM_SRC-1:0]      ex_rs_used_q;
   logic                    stall;

   always_comb begin
      stall = 1'b0;
      for (int unsigned i = 0; i < NUM_SRC; i++) begin
         if (id_valid && id_rs_used[i]) begin
            if (FWD_EN != 0) begin
               if (slot_writes(ex_q, RA_MAX_W'(id_rs_addr[i*RA_W +: RA_W])) && ex_q.is_load)
                  stall = 1'b1;
            end else begin
               // WB needs no stall: the register file writes before it is read.
               if (slot_writes(ex_q,  RA_MAX_W'(id_rs_addr[i*RA_W +: RA_W])) ||
                   slot_writes(mem_q, RA_MAX_W'(id_rs_addr[i*RA_W +: RA_W])))
                  stall = 1'b1;
            end
         end
      end
   end

   assign id_stall = stall & ~flush;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ex_q         <= '0;
         mem_q        <= '0;
         wb_q         <= '0;
         ex_rs_addr_q <= '0;
         ex_rs_used_q <= '0;
         stall_cycles <= '0;
      end else begin
         wb_q          <= mem_q;
         mem_q         <= ex_q;
         ex_q.valid    <= id_valid & ~flush & ~id_stall;
         ex_q.rd       <= RA_MAX_W'(id_rd);
         ex_q.rd_we    <= id_rd_we;
         ex_q.is_load  <= id_is_load;
         ex_rs_addr_q  <= id_rs_addr;
         ex_rs_used_q  <= id_rs_used;
         if (id_stall && stall_cycles != '1)
            stall_cycles <= stall_cycles + CNT_W'(1);
      end
   end

   for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
      fwd_src_sel #(
         .XLEN   (XLEN),
         .RA_W   (RA_W),
         .FWD_EN (FWD_EN)
      ) u_src_sel (
         .rs_addr        (ex_rs_addr_q[i*RA_W +: RA_W]),
         .rs_used        (ex_rs_used_q[i]),
         .mem_slot       (mem_q),
         .wb_slot        (wb_q),
         .rs_data        (ex_rs_data[i*XLEN +: XLEN]),
         .mem_alu_result (mem_alu_result),
         .wb_rd_data     (wb_rd_data),
         .fwd_sel        (ex_fwd_sel[i*2 +: 2]),
         .fwd_data       (ex_fwd_data[i*XLEN +: XLEN])
      );
   end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed bench: forwarding instance (defaults) and a no-forward instance with a 4-bit counter.
module tb_fwd_hazard_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        id_valid;
   logic [9:0]  id_rs_addr;
   logic [1:0]  id_rs_used;
   logic [4:0]  id_rd;
   logic        id_rd_we;
   logic        id_is_load;
   logic        flush;
   logic [63:0] ex_rs_data;
   logic [31:0] mem_alu_result;
   logic [31:0] wb_rd_data;

   logic        a_stall, b_stall;
   logic [3:0]  a_sel, b_sel;
   logic [63:0] a_data, b_data;
   logic [15:0] a_cnt;
   logic [3:0]  b_cnt;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   fwd_hazard_unit u_fwd (
      .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs_addr(id_rs_addr),
      .id_rs_used(id_rs_used), .id_rd(id_rd), .id_rd_we(id_rd_we), .id_is_load(id_is_load),
      .flush(flush), .ex_rs_data(ex_rs_data), .mem_alu_result(mem_alu_result),
      .wb_rd_data(wb_rd_data), .id_stall(a_stall), .ex_fwd_sel(a_sel),
      .ex_fwd_data(a_data), .stall_cycles(a_cnt)
   );

   fwd_hazard_unit #(.FWD_EN(0), .CNT_W(4)) u_nofwd (
      .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs_addr(id_rs_addr),
      .id_rs_used(id_rs_used), .id_rd(id_rd), .id_rd_we(id_rd_we), .id_is_load(id_is_load),
      .flush(flush), .ex_rs_data(ex_rs_data), .mem_alu_result(mem_alu_result),
      .wb_rd_data(wb_rd_data), .id_stall(b_stall), .ex_fwd_sel(b_sel),
      .ex_fwd_data(b_data), .stall_cycles(b_cnt)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drv(input logic v, input logic [4:0] r0, input logic [4:0] r1,
                      input logic [1:0] used, input logic [4:0] rd,
                      input logic we, input logic ld);
      id_valid   = v;
      id_rs_addr = {r1, r0};
      id_rs_used = used;
      id_rd      = rd;
      id_rd_we   = we;
      id_is_load = ld;
   endtask

   task automatic idle(input int n);
      drv(1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0);
      for (int k = 0; k < n; k++) tick();
   endtask

   initial begin
      reset = 1'b1;
      flush = 1'b0;
      ex_rs_data     = {32'hBBBB_0001, 32'hAAAA_0000};
      mem_alu_result = 32'h0000_1234;
      wb_rd_data     = 32'h5555_6666;
      drv(1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0);
      tick();
      tick();
      chk("rst_a_stall", 64'(a_stall), 64'd0);
      chk("rst_a_sel",   64'(a_sel),   64'd0);
      chk("rst_a_data",  a_data,       64'hBBBB_0001_AAAA_0000);
      chk("rst_a_cnt",   64'(a_cnt),   64'd0);
      chk("rst_b_cnt",   64'(b_cnt),   64'd0);
      reset = 1'b0;
      tick();

      // back-to-back ALU: add x5 ; sub x9,x5,x1
      drv(1'b1, 5'd0, 5'd0, 2'b00, 5'd5, 1'b1, 1'b0); #1;
      chk("b2b_prod_stall", 64'(a_stall), 64'd0);
      tick();
      drv(1'b1, 5'd5, 5'd1, 2'b11, 5'd9, 1'b1, 1'b0); #1;
      chk("b2b_cons_stall", 64'(a_stall), 64'd0);
      tick();
      idle(0); #1;
      chk("b2b_sel",  64'(a_sel), 64'h2);
      chk("b2b_data", a_data,     64'hBBBB_0001_0000_1234);
      idle(3);

      // producer two ahead: x6 reaches WB while an unrelated x10 sits in MEM
      drv(1'b1, 5'd0, 5'd0, 2'b00, 5'd6, 1'b1, 1'b0);  tick();
      drv(1'b1, 5'd0, 5'd0, 2'b00, 5'd10, 1'b1, 1'b0); tick();
      drv(1'b1, 5'd2, 5'd6, 2'b11, 5'd11, 1'b1, 1'b0); #1;
      chk("wb_cons_stall", 64'(a_stall), 64'd0);
      tick();
      idle(0); #1;
      chk("wb_sel",  64'(a_sel), 64'h4);
      chk("wb_data", a_data,     64'h5555_6666_AAAA_0000);
      idle(3);

      // same rd in MEM and WB: MEM wins; rs1 matches too but is not used
      drv(1'b1, 5'd0, 5'd0, 2'b00, 5'd6, 1'b1, 1'b0); tick();
      drv(1'b1, 5'd0, 5'd0, 2'b00, 5'd6, 1'b1, 1'b0); tick();
      drv(1'b1, 5'd6, 5'd6, 2'b01, 5'd12, 1'b1, 1'b0); tick();
      idle(0); #1;
      chk("prio_sel",  64'(a_sel), 64'h2);
      chk("prio_data", a_data,     64'hBBBB_0001_0000_1234);
      idle(3);

      // load-use: lw x7 ; add x8,x7,x1
      drv(1'b1, 5'd0, 5'd0, 2'b00, 5'd7, 1'b1, 1'b1); tick();
      drv(1'b1, 5'd7, 5'd1, 2'b11, 5'd8, 1'b1, 1'b0); #1;
      chk("lu_stall_n",  64'(a_stall), 64'd1);
      chk("lu_cnt_n",    64'(a_cnt),   64'd0);
      tick();
      chk("lu_stall_n1", 64'(a_stall), 64'd0);
      chk("lu_cnt_n1",   64'(a_cnt),   64'd1);
      tick();
      idle(0); #1;
      chk("lu_sel",  64'(a_sel), 64'h1);
      chk("lu_data", a_data,     64'hBBBB_0001_5555_6666);
      chk("lu_cnt",  64'(a_cnt), 64'd1);
      idle(3);

      // x0: load to x0 must not stall; ALU write to x0 must not forward
      drv(1'b1, 5'd0, 5'd0, 2'b00, 5'd0, 1'b1, 1'b1); tick();
      drv(1'b1, 5'd0, 5'd0, 2'b11, 5'd3, 1'b1, 1'b0); #1;
      chk("x0_stall", 64'(a_stall), 64'd0);
      drv(1'b1, 5'd0, 5'd0, 2'b00, 5'd0, 1'b1, 1'b0); tick();
      tick();
      drv(1'b1, 5'd0, 5'd0, 2'b11, 5'd3, 1'b1, 1'b0); tick();
      idle(0); #1;
      chk("x0_sel",  64'(a_sel), 64'h0);
      chk("x0_data", a_data,     64'hBBBB_0001_AAAA_0000);
      idle(3);

      // unused operand matching a load destination does not stall
      drv(1'b1, 5'd0, 5'd0, 2'b00, 5'd7, 1'b1, 1'b1); tick();
      drv(1'b1, 5'd3, 5'd7, 2'b01, 5'd8, 1'b1, 1'b0); #1;
      chk("unused_stall", 64'(a_stall), 64'd0);
      tick();
      idle(3);
      chk("a_cnt_end", 64'(a_cnt), 64'd1);

      // no-forward instance from a clean reset
      reset = 1'b1; #1;
      tick();
      reset = 1'b0;
      tick();

      drv(1'b1, 5'd0, 5'd0, 2'b00, 5'd5, 1'b1, 1'b0); #1;
      chk("nf_prod_stall", 64'(b_stall), 64'd0);
      tick();
      drv(1'b1, 5'd5, 5'd0, 2'b01, 5'd9, 1'b1, 1'b0); #1;
      chk("nf_stall_1", 64'(b_stall), 64'd1);
      chk("nf_sel_1",   64'(b_sel),   64'd0);
      tick();
      chk("nf_stall_2", 64'(b_stall), 64'd1);
      tick();
      chk("nf_sel_memw", 64'(b_sel),  64'd0);
      chk("nf_data",    b_data,       64'hBBBB_0001_AAAA_0000);
      chk("nf_stall_3", 64'(b_stall), 64'd0);
      chk("nf_cnt",     64'(b_cnt),   64'd2);
      tick();
      idle(3);

      // flush during a stall wins and leaves the counter alone
      drv(1'b1, 5'd0, 5'd0, 2'b00, 5'd5, 1'b1, 1'b0); tick();
      drv(1'b1, 5'd5, 5'd0, 2'b01, 5'd9, 1'b1, 1'b0);
      flush = 1'b1; #1;
      chk("fl_stall", 64'(b_stall), 64'd0);
      chk("fl_cnt",   64'(b_cnt),   64'd2);
      tick();
      flush = 1'b0; #1;
      chk("fl_stall_mem", 64'(b_stall), 64'd1);
      tick();
      chk("fl_stall_wb", 64'(b_stall), 64'd0);
      chk("fl_cnt_after", 64'(b_cnt),  64'd3);
      tick();
      idle(3);

      // saturation: two stall cycles per producer/consumer pair
      for (int k = 0; k < 6; k++) begin
         drv(1'b1, 5'd0, 5'd0, 2'b00, 5'd5, 1'b1, 1'b0); tick();
         drv(1'b1, 5'd5, 5'd0, 2'b01, 5'd9, 1'b1, 1'b0); tick();
         tick();
      end
      chk("sat_reach", 64'(b_cnt), 64'hF);
      for (int k = 0; k < 4; k++) begin
         drv(1'b1, 5'd0, 5'd0, 2'b00, 5'd5, 1'b1, 1'b0); tick();
         drv(1'b1, 5'd5, 5'd0, 2'b01, 5'd9, 1'b1, 1'b0); tick();
         tick();
      end
      chk("sat_hold", 64'(b_cnt), 64'hF);
      idle(3);

      // reset in the middle of a stall
      drv(1'b1, 5'd0, 5'd0, 2'b00, 5'd5, 1'b1, 1'b0); tick();
      drv(1'b1, 5'd5, 5'd0, 2'b01, 5'd9, 1'b1, 1'b0); #1;
      chk("mr_stall_pre", 64'(b_stall), 64'd1);
      reset = 1'b1; #1;
      chk("mr_stall", 64'(b_stall), 64'd0);
      chk("mr_cnt",   64'(b_cnt),   64'd0);
      tick();
      chk("mr_stall_hold", 64'(b_stall), 64'd0);
      reset = 1'b0;
      idle(2);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
